// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
package seg_sched_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0]              digit_t;
    typedef logic [4*NUM_DIGITS-1:0] digits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

endpackage

// File: rtl/seg_refresh_timer.sv
// Digit-scan prescaler: one scan_tick per REFRESH_DIV cycles, frame_done on the last digit slot.
module seg_refresh_timer
    import seg_sched_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       scan_tick,
    output logic [1:0] digit_idx,
    output logic       frame_done
);

    localparam int              CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    assign scan_tick  = (presc_q == LAST);
    assign frame_done = scan_tick && (idx_q == 2'(NUM_DIGITS - 1));
    assign digit_idx  = idx_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        presc_d = presc_q + CW'(1);
        idx_d   = idx_q;
        if (scan_tick) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin owner of a shared 4-digit display, switching only at frame boundaries.
// Optional blink of the owned display is built when SEG_BLINK_EN is defined.
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int HOLD_FRAMES  = 50
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] digits0,
    input  logic        req1,
    input  logic [15:0] digits1,
`ifdef SEG_BLINK_EN
    input  logic        blink_en,
`endif
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  num0,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic        scan_tick,
    output logic [1:0]  digit_idx,
    output logic        frame_done,
    output logic        blank
);

    localparam int            HW       = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    digits_t       num_q, num_d;

    seg_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_tick  (scan_tick),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        num_d   = num_q;
        if (frame_done) begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
                    else if (req0)     state_d = OWN0;
                    else if (req1)     state_d = OWN1;
                end
                OWN0: begin
                    if (!req0)                           state_d = req1 ? OWN1 : IDLE;
                    else if (req1 && hold_q >= HOLD_MAX) state_d = OWN1;
                end
                OWN1: begin
                    if (!req1)                           state_d = req0 ? OWN0 : IDLE;
                    else if (req0 && hold_q >= HOLD_MAX) state_d = OWN0;
                end
                default: state_d = IDLE;
            endcase

            if (state_d != IDLE && state_d != state_q) begin
                last_d = (state_d == OWN1);
                hold_d = HW'(1);
            end else if (state_d != IDLE && hold_q < HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end

            // The owner's digits are captured only here, so a frame never shows a mix.
            if (state_d == OWN0)      num_d = digits0;
            else if (state_d == OWN1) num_d = digits1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            num_q   <= num_d;
        end
    end

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign num0 = num_q[3:0];
    assign num1 = num_q[7:4];
    assign num2 = num_q[11:8];
    assign num3 = num_q[15:12];

`ifdef SEG_BLINK_EN
    localparam int            BW        = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (state_q == IDLE || !blink_en) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (frame_done) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blank = (state_q == IDLE) || blink_off_q;
`else
    assign blank = (state_q == IDLE);
`endif

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// requests checked every cycle against a frame-level behavioural model.
module tb_seg_display_scheduler;

    localparam int DIV   = 4;
    localparam int HOLD  = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] digits0 = '0, digits1 = '0;
`ifdef SEG_BLINK_EN
    logic        blink_en = 1'b0;
`endif
    logic        gnt0, gnt1, scan_tick, frame_done, blank;
    logic [3:0]  num0, num1, num2, num3;
    logic [1:0]  digit_idx;

    seg_display_scheduler #(
        .REFRESH_DIV  (DIV),
        .HOLD_FRAMES  (HOLD)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_FRAMES (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .digits0    (digits0),
        .req1       (req1),
        .digits1    (digits1),
`ifdef SEG_BLINK_EN
        .blink_en   (blink_en),
`endif
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .num0       (num0),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .scan_tick  (scan_tick),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: position within the frame, current owner (-1 = none), and
    // the request/digit snapshot taken at each frame boundary.
    int          cyc     = 0;
    int          m_owner = -1;
    int          m_last  = 1;
    int          m_hold  = 0;
    logic [15:0] m_num   = '0;
    bit          chk_en  = 1'b0;

    task automatic model_step();
        bit          r[2];
        logic [15:0] d[2];
        int          nxt;
        int          other;
        if (!rst_n) begin
            cyc = 0; m_owner = -1; m_last = 1; m_hold = 0; m_num = '0; chk_en = 1'b1;
            return;
        end
        if (cyc == FRAME - 1) begin
            r[0] = req0; r[1] = req1; d[0] = digits0; d[1] = digits1;
            nxt = m_owner;
            if (m_owner < 0) begin
                if (r[0] && r[1]) nxt = 1 - m_last;
                else if (r[0])    nxt = 0;
                else if (r[1])    nxt = 1;
            end else begin
                other = 1 - m_owner;
                if (!r[m_owner])                  nxt = r[other] ? other : -1;
                else if (r[other] && m_hold >= HOLD) nxt = other;
            end
            if (nxt >= 0) begin
                if (nxt != m_owner) begin m_last = nxt; m_hold = 1; end
                else m_hold++;
                m_num = d[nxt];
            end
            m_owner = nxt;
        end
        cyc = (cyc + 1) % FRAME;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [3:0] e_timer;
            e_timer = {(cyc % DIV) == DIV - 1, 2'((cyc / DIV) % 4), cyc == FRAME - 1};
            check("timer", {28'd0, scan_tick, digit_idx, frame_done}, {28'd0, e_timer});
            check("gnt", {30'd0, gnt1, gnt0}, {30'd0, m_owner == 1, m_owner == 0});
            check("blank", {31'd0, blank}, {31'd0, m_owner < 0});
            check("num", {16'd0, num3, num2, num1, num0}, {16'd0, m_num});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Returns at 1 time unit after the posedge that consumed the next frame_done.
    task automatic wait_fd();
        int k = 0;
        @(negedge clk);
        while (!frame_done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("fd_timeout", 32'd0, 32'd1);
        next_cycle();
    endtask

    function automatic logic [31:0] outs_gnt();
        return {30'd0, gnt1, gnt0};
    endfunction

    function automatic logic [31:0] outs_num();
        return {16'd0, num3, num2, num1, num0};
    endfunction

    initial begin
        int ticks, fds;

        do_reset();
        check("rst_tick", {31'd0, scan_tick}, 32'd0);
        check("rst_idx", {30'd0, digit_idx}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        check("rst_gnt", outs_gnt(), 32'd0);
        check("rst_blank", {31'd0, blank}, 32'd1);
        check("rst_num", outs_num(), 32'd0);

        ticks = 0; fds = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (scan_tick)  ticks++;
            if (frame_done) fds++;
        end
        check("tick_count", 32'(ticks), 32'd8);
        check("fd_count", 32'(fds), 32'd2);
        check("idle_gnt", outs_gnt(), 32'd0);
        next_cycle();

        req0 = 1'b1; digits0 = 16'h1234;
        wait_fd();
        check("single_gnt", outs_gnt(), 32'b01);
        check("single_num", outs_num(), 32'h1234);
        check("single_blank", {31'd0, blank}, 32'd0);

        do_reset();
        req0 = 1'b1; req1 = 1'b1; digits0 = 16'h1111; digits1 = 16'h2222;
        wait_fd(); check("both_first", outs_gnt(), 32'b01);
        wait_fd(); check("both_hold0", outs_gnt(), 32'b01);
        wait_fd(); check("both_switch", outs_gnt(), 32'b10);
        check("both_num1", outs_num(), 32'h2222);
        wait_fd(); check("both_hold1", outs_gnt(), 32'b10);
        wait_fd(); check("both_back", outs_gnt(), 32'b01);
        wait_fd(); wait_fd();
        check("own1_again", outs_gnt(), 32'b10);

        repeat (3) next_cycle();
        digits1 = 16'h5678;
        repeat (2) next_cycle();
        check("mid_frame_num", outs_num(), 32'h2222);
        wait_fd();
        check("next_frame_num", outs_num(), 32'h5678);

        wait_fd(); wait_fd();
        check("own0_before_release", outs_gnt(), 32'b01);
        req0 = 1'b0; req1 = 1'b0;
        wait_fd();
        check("release_gnt", outs_gnt(), 32'd0);
        check("release_blank", {31'd0, blank}, 32'd1);
        check("idle_keeps_num", outs_num(), 32'h1111);

        repeat (4) next_cycle();
        req0 = 1'b1;
        repeat (3) next_cycle();
        req0 = 1'b0;
        wait_fd();
        check("short_pulse", outs_gnt(), 32'd0);

        req1 = 1'b1;
        wait_fd();
        check("own1_single", outs_gnt(), 32'b10);
        repeat (5) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        check("midrst_gnt", outs_gnt(), 32'd0);
        check("midrst_num", outs_num(), 32'd0);
        check("midrst_blank", {31'd0, blank}, 32'd1);
        check("midrst_timer", {29'd0, scan_tick, digit_idx}, 32'd0);
        rst_n = 1'b1;
        req1 = 1'b0;

        repeat (3000) begin
            if ($urandom_range(19) == 0) req0 = ~req0;
            if ($urandom_range(19) == 0) req1 = ~req1;
            if ($urandom_range(7) == 0)  digits0 = 16'($urandom);
            if ($urandom_range(7) == 0)  digits1 = 16'($urandom);
            rst_n = ($urandom_range(499) != 0);
            next_cycle();
        end
        rst_n = 1'b1;
        repeat (FRAME) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
